// File: rtl/wide_add_pkg.sv
// Shared types and width helpers for the wide add sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: the sequencer state enum and the constant functions that
// derive the total operand width and the slice-index width.
package wide_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Total operand width W = SLICE_W * NUM_SLICES.
  function automatic int total_width(input int slice_w, input int num_slices);
    return slice_w * num_slices;
  endfunction

  // Width of the slice counter; at least one bit so the register exists.
  function automatic int idx_width(input int num_slices);
    return (num_slices > 1) ? $clog2(num_slices) : 1;
  endfunction

endpackage

// File: rtl/wide_add_sequencer_cla_slice.sv
// Combinational SLICE_W-bit carry-lookahead adder slice.
// Latency: 0 cycles (purely combinational).
// Backpressure: none (no handshake).
//
// Ports:
//   a, b  SLICE_W-bit addends
//   ci    carry in to bit 0
//   s     SLICE_W-bit sum
//   co    carry out of the top bit
module cla_slice #(
  parameter int SLICE_W = 16
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Carry into bit n as a flat sum of products:
  //   c[n] = OR_j ( g[j] & p[j+1] & ... & p[n-1] )  |  ( p[0] & ... & p[n-1] & ci )
  // Each carry is built directly from g/p/ci, never from a lower carry.
  function automatic logic lookahead(input logic [SLICE_W-1:0] gv,
                                     input logic [SLICE_W-1:0] pv,
                                     input logic               cv,
                                     input int                 n);
    logic acc;
    logic term;
    acc = 1'b0;
    for (int j = 0; j < n; j++) begin
      term = gv[j];
      for (int k = j + 1; k < n; k++) begin
        term = term & pv[k];
      end
      acc = acc | term;
    end
    term = cv;
    for (int k = 0; k < n; k++) begin
      term = term & pv[k];
    end
    acc = acc | term;
    return acc;
  endfunction

  assign c[0] = ci;

  for (genvar i = 1; i <= SLICE_W; i++) begin : g_carry
    assign c[i] = lookahead(g, p, ci, i);
  end

  assign s  = p ^ c[SLICE_W-1:0];
  assign co = c[SLICE_W];

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide adder that reuses one SLICE_W-bit CLA slice, LS slice first, carry registered between slices.
// Latency: NUM_SLICES cycles from accept to out_valid; issue interval NUM_SLICES+2.
// Backpressure: result held in DONE (sum/cout frozen) until out_ready; in_ready low while busy.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    operand handshake (in_ready depends on state only)
//   a, b, cin            W-bit operands and carry in
//   out_valid/out_ready  result handshake
//   sum, cout            A + B + cin mod 2^W, and carry out of bit W-1
//   busy                 high while an operation is in flight or awaiting pickup
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter  int SLICE_W    = 16,
  parameter  int NUM_SLICES = 4,
  localparam int W          = total_width(SLICE_W, NUM_SLICES),
  localparam int IW         = idx_width(NUM_SLICES)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  state_t state;
  state_t state_nxt;

  logic [W-1:0]       a_reg;
  logic [W-1:0]       b_reg;
  logic [W-1:0]       sum_reg;
  logic               carry_reg;
  logic               cout_reg;
  logic [IW-1:0]      idx;

  logic [31:0]        base;
  logic               last;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_co;

  // Bit offset of the slice currently being processed.
  assign base = 32'(idx) * 32'(SLICE_W);
  assign last = (idx == IW'(NUM_SLICES - 1));

  cla_slice #(
    .SLICE_W (SLICE_W)
  ) u_cla_slice (
    .a  (a_reg[base +: SLICE_W]),
    .b  (b_reg[base +: SLICE_W]),
    .ci (carry_reg),
    .s  (slice_s),
    .co (slice_co)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs; outputs are decoded from state alone.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath. sum is not cleared on accept: partial slices overwrite it
  // during RUN and it is only meaningful once out_valid is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx       <= '0;
          end
        end
        RUN: begin
          sum_reg[base +: SLICE_W] <= slice_s;
          carry_reg                <= slice_co;
          if (last) begin
            cout_reg <= slice_co;
            idx      <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: begin
          // DONE: hold everything until the consumer takes the result.
        end
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-cycle sequencer that adds two wide operands using one narrow carry-lookahead adder slice. It processes one SLICE_W-bit slice per clock, least significant first, and registers the carry between slices. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It trades latency for area when full-width carry-lookahead is too large or too slow.

## Interface
- SLICE_W, 16: width of the adder slice in bits (≥ 2).
- NUM_SLICES, 4: slices per operation (≥ 2); total width W = SLICE_W*NUM_SLICES.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- in_valid  input  1  operands valid.
- in_ready  output  1  sequencer can accept operands.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  W  A + B + cin, modulo 2^W.
- cout  output  1  carry out of bit W-1.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a, b into operand registers, latch cin into the carry register, clear slice counter idx to 0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the slice adder computes {c, s} = a_slice[idx] + b_slice[idx] + carry_reg.
  - s is written into result slice idx; carry_reg <= c; idx <= idx+1.
  - When idx==NUM_SLICES-1: write the final slice, set cout <= c, go to DONE.
- DONE:
  - out_valid=1; sum and cout held stable.
  - On out_valid&out_ready go to IDLE.
  - Inputs are ignored while not in IDLE.
- Width rules:
  - idx is $clog2(NUM_SLICES) bits.
  - Slice adder output is SLICE_W+1 bits, with the top bit as carry.
  - No saturation; overflow is reported only through cout.
- Reset (rst_n low at a rising edge), including mid-RUN or DONE:
  - State goes to IDLE; operation is aborted and no result is produced.
  - out_valid=0, in_ready=1 after reset, busy=0, sum=0, cout=0, idx=0, carry_reg=0.
- in_valid asserted during reset is not accepted.

## Timing
- Accept edge = T0. Slices 0..NUM_SLICES-1 are written at edges T1..T(NUM_SLICES).
- out_valid rises after edge T(NUM_SLICES): latency NUM_SLICES cycles from accept to out_valid.
- Minimum issue interval is NUM_SLICES+2 cycles: accept, NUM_SLICES RUN cycles, one DONE cycle with immediate out_ready, then back to IDLE.
- Back-pressure: out_valid stays high and sum/cout stay frozen until out_ready. No timeout.
- in_ready is combinational from state only. It does not depend on in_valid or out_ready.
- The slice-adder critical path is SLICE_W bits. There is no combinational path from any input to any output.
- Partial sum bits are visible on sum during RUN, but consumers sample only when out_valid=1.

## Structure
- Package wide_add_pkg:
  - state enum (IDLE, RUN, DONE);
  - localparam-style helper for W and the idx width.
- Sub-module cla_slice:
  - purely combinational SLICE_W-bit carry-lookahead adder;
  - ports a, b, ci, s, co;
  - generate/propagate per bit, ripple-free carry expression per bit.
- The sequencer instantiates exactly one cla_slice. Slice muxing is done by idx-indexed part-select on the operand registers.

## Test plan
All scenarios use the defaults (SLICE_W=16, NUM_SLICES=4, W=64).
- Full carry propagation: a=64'hFFFF_FFFF_FFFF_FFFF, b=64'h1, cin=0 → sum=0, cout=1, out_valid exactly 4 cycles after accept.
- No-carry baseline: a=64'h0001_0002_0003_0004, b=64'h0010_0020_0030_0040, cin=1 → sum=64'h0011_0022_0033_0045, cout=0.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid → sum/cout stable, in_ready=0 throughout, in_valid pulses ignored. Then out_ready=1 → IDLE next cycle and in_ready=1.
- Mid-operation reset: accept a=64'h8000_0000_0000_0000, b=64'h8000_0000_0000_0000, drop rst_n at the second RUN cycle → next cycle IDLE, out_valid=0, sum=0, cout=0. A new op (a=1, b=1) then gives sum=2.
- Back-to-back ops with out_ready tied high: 100 random operand/cin triples → each result matches a 65-bit reference sum, issue interval exactly 6 cycles.
- Parameter sweep: SLICE_W=8, NUM_SLICES=2 with a=16'hFF00, b=16'h0100 → sum=0, cout=1, latency 2 cycles.
